// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Holds the program counter and fetches instruction words from
//            instruction memory over a req/gnt/rvalid interface. Returned
//            words are buffered in a small FIFO and presented to the
//            decode/control stage with a valid/ready handshake. A taken
//            branch (pcsrc) redirects the PC and flushes wrong-path words.
//
// Parameters:
//   RESET_PC  - PC loaded on reset (bits [1:0] must be zero)
//   QDEPTH    - fetch queue depth (power of two, >= 2)
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   pcsrc               - redirect request from the control unit
//   branch_target[31:0] - redirect address (bits [1:0] ignored)
//   imem_req/imem_addr  - fetch request and word address (held until gnt)
//   imem_gnt            - request accepted this cycle
//   imem_rvalid/rdata   - returned instruction word
//   instr/instr_pc      - queue head word and its PC
//   instr_valid         - queue head valid
//   instr_ready         - downstream accepts the head
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   fetch_count[31:0]   - saturating count of instructions consumed
//   flush_count[15:0]   - saturating count of redirect cycles
//
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcsrc,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] flush_count
`endif
);

    localparam int                c_ptr_w = $clog2(QDEPTH);
    localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w + 1)'(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t               r_state;
    logic [31:0]          r_pc;        // address of the next fetch to issue
    logic [31:0]          r_addr;      // address of the request in flight
    logic                 r_req;
    logic                 r_discard;   // response of the in-flight request is wrong-path

    logic [31:0]          r_q_instr [QDEPTH];
    logic [31:0]          r_q_pc    [QDEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;

    logic                 w_valid;
    logic                 w_pop;
    logic                 w_push;
    logic [c_ptr_w:0]     w_count_next;
    logic                 w_room;
    logic [31:0]          w_target;
    logic                 w_unused_bits;

    assign w_target      = {branch_target[31:2], 2'b00};
    assign w_unused_bits = ^branch_target[1:0];

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && instr_ready;
    // Data arriving together with a redirect, or flagged as wrong-path, is dropped.
    assign w_push  = (r_state == S_WAIT) && imem_rvalid && !r_discard && !pcsrc;

    assign w_count_next = r_count
                        + {{c_ptr_w{1'b0}}, w_push}
                        - {{c_ptr_w{1'b0}}, w_pop};

    // A new request is allowed only if its response is guaranteed a slot:
    // nothing is in flight whenever this is evaluated, so the occupancy after
    // this edge's push/pop is the whole in-flight accounting.
    assign w_room = (w_count_next < c_depth);

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr_valid = w_valid;
    assign instr       = w_valid ? r_q_instr[r_rd_ptr] : 32'h0000_0000;
    assign instr_pc    = w_valid ? r_q_pc[r_rd_ptr]    : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_addr    <= RESET_PC;
            r_req     <= 1'b0;
            r_discard <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_instr[i] <= 32'h0000_0000;
                r_q_pc[i]    <= 32'h0000_0000;
            end
        end else begin
            // ---------------- fetch queue ----------------
            if (pcsrc) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_q_instr[r_wr_ptr] <= imem_rdata;
                    r_q_pc[r_wr_ptr]    <= r_addr;
                    r_wr_ptr            <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= w_count_next;
            end

            // ---------------- fetch state machine ----------------
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    if (pcsrc) begin
                        r_pc <= w_target;
                    end
                end

                S_REQ: begin
                    if (r_req) begin
                        // Request is held at its address until granted, even
                        // across a redirect; its response is then discarded.
                        if (imem_gnt) begin
                            r_req   <= 1'b0;
                            r_state <= S_WAIT;
                            if (!pcsrc && !r_discard) begin
                                r_pc <= r_pc + 32'd4;
                            end
                        end
                        if (pcsrc) begin
                            r_pc      <= w_target;
                            r_discard <= 1'b1;
                        end
                    end else if (pcsrc) begin
                        // Nothing outstanding: fetch the target right away.
                        r_pc   <= w_target;
                        r_req  <= 1'b1;
                        r_addr <= w_target;
                    end else if (w_room) begin
                        r_req  <= 1'b1;
                        r_addr <= r_pc;
                    end
                end

                S_WAIT: begin
                    if (pcsrc) begin
                        r_pc <= w_target;
                    end
                    if (imem_rvalid) begin
                        r_state   <= S_REQ;
                        r_discard <= 1'b0;
                        // Next request goes out in the cycle after the response.
                        if (pcsrc || w_room) begin
                            r_req  <= 1'b1;
                            r_addr <= pcsrc ? w_target : r_pc;
                        end
                    end else if (pcsrc) begin
                        r_discard <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [15:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= 32'h0000_0000;
            r_flush_count <= 16'h0000;
        end else begin
            if (w_pop && (r_fetch_count != 32'hFFFF_FFFF)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (pcsrc && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign flush_count = r_flush_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit. A second
//            instance with RESET_PC = 0xFFFF_FFF8 covers PC wrap-around.
//            Memory grants combinationally when enabled and returns data one
//            cycle after the grant; the word for address A is
//            {A[15:0], ~A[15:0]}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic        ready;
    logic        gnt_en;
    logic        rv_force;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        rv_q    = 1'b0;
    logic [31:0] rv_addr = 32'h0;

    logic        req2;
    logic [31:0] addr2;
    logic        gnt2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;
    logic        valid2;
    logic        rv2_q    = 1'b0;
    logic [31:0] rv2_addr = 32'h0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
    logic [31:0] fetch_count2;
    logic [15:0] flush_count2;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Instruction memory models
    assign imem_gnt    = imem_req & gnt_en;
    assign imem_rvalid = rv_q | rv_force;
    assign imem_rdata  = rv_force ? 32'h1234_5678 : mem_word(rv_addr);
    always @(posedge clk) begin
        rv_q    <= imem_req & imem_gnt;
        rv_addr <= imem_addr;
    end

    assign gnt2    = req2;
    assign rvalid2 = rv2_q;
    assign rdata2  = mem_word(rv2_addr);
    always @(posedge clk) begin
        rv2_q    <= req2 & gnt2;
        rv2_addr <= addr2;
    end

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pcsrc         (pcsrc),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count),
        .flush_count   (flush_count)
`endif
    );

    instr_fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8),
        .QDEPTH   (2)
    ) dut_wrap (
        .clk           (clk),
        .rst           (rst),
        .pcsrc         (1'b0),
        .branch_target (32'h0000_0000),
        .imem_req      (req2),
        .imem_addr     (addr2),
        .imem_gnt      (gnt2),
        .imem_rvalid   (rvalid2),
        .imem_rdata    (rdata2),
        .instr         (instr2),
        .instr_pc      (instr_pc2),
        .instr_valid   (valid2),
        .instr_ready   (1'b1)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count2),
        .flush_count   (flush_count2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        pcsrc         = 1'b0;
        branch_target = 32'h0;
        ready         = 1'b1;
        gnt_en        = 1'b1;
        rv_force      = 1'b0;

        // ---------------- reset values ----------------
        tick();
        tick();
        check("rst_req",      32'(imem_req),    32'h0);
        check("rst_addr",     imem_addr,        32'h0);
        check("rst_valid",    32'(instr_valid), 32'h0);
        check("rst_instr",    instr,            32'h0);
        check("rst_instr_pc", instr_pc,         32'h0);
        check("rst_addr_wrap", addr2,           32'hFFFF_FFF8);
`ifdef FETCH_PERF_CNT_EN
        check("rst_fetch_cnt", fetch_count,        32'h0);
        check("rst_flush_cnt", 32'(flush_count),   32'h0);
`endif

        // ---------------- streaming fetch ----------------
        rst = 1'b0;
        tick();                                         // e1: IDLE -> REQ
        check("e1_req",        32'(imem_req),    32'h0);
        tick();                                         // e2: first request
        check("e2_req",        32'(imem_req),    32'h1);
        check("e2_addr",       imem_addr,        32'h0);
        check("e2_addr_wrap",  addr2,            32'hFFFF_FFF8);
        tick();                                         // e3: granted
        check("e3_req",        32'(imem_req),    32'h0);
        check("e3_valid",      32'(instr_valid), 32'h0);
        tick();                                         // e4: first word queued
        check("e4_valid",      32'(instr_valid), 32'h1);
        check("e4_instr_pc",   instr_pc,         32'h0);
        check("e4_instr",      instr,            32'h0000_FFFF);
        check("e4_addr",       imem_addr,        32'h4);
        check("e4_addr_wrap",  addr2,            32'hFFFF_FFFC);
        tick();
        tick();                                         // e6
        check("e6_instr_pc",   instr_pc,         32'h4);
        check("e6_addr",       imem_addr,        32'h8);
        check("e6_addr_wrap",  addr2,            32'h0000_0000);
        tick();
        tick();                                         // e8
        check("e8_instr_pc",   instr_pc,         32'h8);
        check("e8_instr",      instr,            32'h0008_FFF7);
        check("e8_addr",       imem_addr,        32'hC);

        // ---------------- backpressure: queue fills ----------------
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        ready = 1'b0;
        repeat (5) tick();                              // e1..e5
        for (int i = 0; i < 5; i++) begin               // e6..e10
            tick();
            check("full_req", 32'(imem_req), 32'h0);
        end
        check("full_valid",    32'(instr_valid), 32'h1);
        check("full_head_pc",  instr_pc,         32'h0);
        ready = 1'b1;
        tick();                                         // e11: pop pc 0, fetch resumes
        check("drain_head_pc", instr_pc,         32'h4);
        check("drain_req",     32'(imem_req),    32'h1);
        check("drain_addr",    imem_addr,        32'h8);
        tick();                                         // e12: pop pc 4
        check("drain_empty",   32'(instr_valid), 32'h0);
        tick();                                         // e13
        check("resume_pc",     instr_pc,         32'h8);
        check("resume_instr",  instr,            32'h0008_FFF7);

        // ---------------- redirect with request outstanding ----------------
        tick();                                         // e14
        tick();                                         // e15
        check("pre_br_addr",   imem_addr,        32'h10);
        check("pre_br_req",    32'(imem_req),    32'h1);
        check("pre_br_head",   instr_pc,         32'hC);
        pcsrc         = 1'b1;
        branch_target = 32'h0000_0103;
        tick();                                         // e16: granted + redirect
        pcsrc = 1'b0;
        check("br_flush_valid", 32'(instr_valid), 32'h0);
        check("br_req",         32'(imem_req),    32'h0);
        tick();                                         // e17: 0x10 data dropped
        check("br_drop_valid",  32'(instr_valid), 32'h0);
        check("br_new_req",     32'(imem_req),    32'h1);
        check("br_new_addr",    imem_addr,        32'h100);
        tick();                                         // e18
        check("br_wait_valid",  32'(instr_valid), 32'h0);
        tick();                                         // e19
        check("br_target_pc",   instr_pc,         32'h100);
        check("br_target_instr", instr,           32'h0100_FEFF);
`ifdef FETCH_PERF_CNT_EN
        check("br_fetch_cnt",   fetch_count,        32'd4);
        check("br_flush_cnt",   32'(flush_count),   32'd1);
`endif

        // ---------------- grant stall ----------------
        gnt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin               // e20..e24
            tick();
            check("stall_req",  32'(imem_req), 32'h1);
            check("stall_addr", imem_addr,     32'h104);
        end
        ready  = 1'b0;
        gnt_en = 1'b1;
        tick();                                         // e25: granted
        check("stall_gnt_valid", 32'(instr_valid), 32'h0);
        tick();                                         // e26: one push
        check("stall_push_pc",   instr_pc,         32'h104);
        check("stall_next_addr", imem_addr,        32'h108);
        gnt_en = 1'b0;
        ready  = 1'b1;
        tick();                                         // e27: single entry popped
        check("stall_one_entry", 32'(instr_valid), 32'h0);

        // ---------------- redirect while request not yet granted ----------------
        pcsrc         = 1'b1;
        branch_target = 32'h0000_0200;
        tick();                                         // e28
        pcsrc = 1'b0;
        check("ungr_req_held",  32'(imem_req), 32'h1);
        check("ungr_addr_held", imem_addr,     32'h108);
        gnt_en = 1'b1;
        tick();                                         // e29: old request granted
        tick();                                         // e30: old data dropped
        check("ungr_drop_valid", 32'(instr_valid), 32'h0);
        check("ungr_new_addr",   imem_addr,        32'h200);
        tick();                                         // e31
        tick();                                         // e32
        check("ungr_target_pc",    instr_pc, 32'h200);
        check("ungr_target_instr", instr,    32'h0200_FDFF);
`ifdef FETCH_PERF_CNT_EN
        check("ungr_fetch_cnt",  fetch_count,      32'd6);
        check("ungr_flush_cnt",  32'(flush_count), 32'd2);
`endif

        // ---------------- reset while waiting ----------------
        ready = 1'b0;
        tick();                                         // e33: in WAIT with one entry
        check("wait_entry_valid", 32'(instr_valid), 32'h1);
        check("wait_entry_pc",    instr_pc,         32'h200);
        rst = 1'b1;
        tick();
        check("mid_rst_req",   32'(imem_req),    32'h0);
        check("mid_rst_valid", 32'(instr_valid), 32'h0);
        check("mid_rst_pc",    instr_pc,         32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("mid_rst_fetch_cnt", fetch_count,      32'h0);
        check("mid_rst_flush_cnt", 32'(flush_count), 32'h0);
`endif
        rst      = 1'b0;
        rv_force = 1'b1;                                // stray responses after reset
        tick();                                         // e1
        check("stray_valid_e1", 32'(instr_valid), 32'h0);
        tick();                                         // e2
        check("stray_valid_e2", 32'(instr_valid), 32'h0);
        check("post_rst_req",   32'(imem_req),    32'h1);
        check("post_rst_addr",  imem_addr,        32'h0);
        rv_force = 1'b0;
        tick();                                         // e3
        tick();                                         // e4
        check("post_rst_pc",    instr_pc,         32'h0);
        check("post_rst_instr", instr,            32'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
